acc_offload_dispatcher: RTL and testbench

//  Sits between the core offload port and NumAcc accelerators. Broadcasts each offloaded instruction to all

---
 rtl/acc_pkg.sv | 37 +++
 rtl/acc_rr_arb.sv | 54 +++++
 rtl/acc_offload_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_acc_offload_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload path: predecoder handshake,
// accelerator request/response payloads and dispatcher FSM states.
package acc_pkg;

  localparam int unsigned AccDataWidth = 32;

  typedef struct packed {
    logic [31:0] instr;
  } prd_req_t;

  typedef struct packed {
    logic       p_accept;
    logic [1:0] p_writeback;
  } prd_rsp_t;

  // rs[0] is rs1 and occupies the least significant operand slot
  typedef struct packed {
    logic [31:0]                  instr;
    logic [2:0][AccDataWidth-1:0] rs;
    logic [4:0]                   rd;
  } acc_req_t;

  typedef struct packed {
    logic [AccDataWidth-1:0] data;
    logic [4:0]              rd;
  } acc_rsp_t;

  typedef enum logic {
    DISP_IDLE,
    DISP_ISSUE
  } disp_state_e;

  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_rr_arb.sv
// Round-robin arbiter: priority starts at the pointer and wraps; the pointer
// moves past the winner only when the caller consumes the grant.
module acc_rr_arb
  import acc_pkg::*;
#(
  parameter int unsigned NumAcc = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NumAcc-1:0] i_req,
  input  logic              i_advance,
  output logic [NumAcc-1:0] o_grant,
  output logic              o_valid
);

  localparam int unsigned PtrW = idxWidth(NumAcc);

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_winner;
  logic [PtrW-1:0] w_idx;
  logic [PtrW:0]   w_sum;
  logic [PtrW-1:0] w_ptrNext;

  always_comb begin
    o_grant  = '0;
    o_valid  = 1'b0;
    w_winner = r_ptr;
    w_sum    = '0;
    w_idx    = '0;
    for (int off = 0; off < NumAcc; off++) begin
      w_sum = {1'b0, r_ptr} + (PtrW+1)'(off);
      if (w_sum >= (PtrW+1)'(NumAcc)) begin
        w_sum = w_sum - (PtrW+1)'(NumAcc);
      end
      w_idx = w_sum[PtrW-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_winner       = w_idx;
      end
    end
  end

  assign w_ptrNext = (w_winner == PtrW'(NumAcc - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && o_valid) begin
      r_ptr <= w_ptrNext;
    end
  end

endmodule

// File: rtl/acc_offload_dispatcher.sv
// Offload dispatcher: issues core requests to the lowest accepting accelerator
// and merges accelerator writebacks into one core response port.
module acc_offload_dispatcher
  import acc_pkg::*;
#(
  parameter int unsigned NumAcc         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataWidth      = AccDataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_q_valid_i,
  output logic                   core_q_ready_o,
  input  logic [31:0]            core_q_instr_i,
  input  logic [3*DataWidth-1:0] core_q_rs_i,
  input  logic [4:0]             core_q_rd_i,
  output logic                   core_k_accept_o,
  output logic                   core_k_wb_o,
  output prd_req_t               prd_req_o,
  input  prd_rsp_t [NumAcc-1:0]  prd_rsp_i,
  output logic [NumAcc-1:0]      acc_q_valid_o,
  input  logic [NumAcc-1:0]      acc_q_ready_i,
  output acc_req_t               acc_q_o,
  input  logic [NumAcc-1:0]      acc_p_valid_i,
  output logic [NumAcc-1:0]      acc_p_ready_o,
  input  acc_rsp_t [NumAcc-1:0]  acc_p_i,
  output logic                   core_p_valid_o,
  input  logic                   core_p_ready_i,
  output acc_rsp_t               core_p_o
);

  localparam int unsigned TgtW = idxWidth(NumAcc);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  disp_state_e     r_state;
  disp_state_e     w_nextState;
  logic [TgtW-1:0] r_target;
  acc_req_t        r_req;
  logic [CntW-1:0] r_count;
  logic            r_rspValid;
  acc_rsp_t        r_rsp;

  logic            w_anyAccept;
  logic            w_anyAcceptWb;
  logic            w_lowestWb;
  logic [TgtW-1:0] w_lowest;
  logic            w_atLimit;
  logic            w_qReady;
  logic            w_acceptFire;
  logic            w_inc;
  logic            w_dec;
  logic            w_load;
  logic [NumAcc-1:0] w_grant;
  logic            w_grantValid;
  acc_rsp_t        w_rspSel;

  assign prd_req_o.instr = core_q_instr_i;

  // Descending scan so the last hit is the lowest accepting index.
  always_comb begin
    w_anyAccept   = 1'b0;
    w_anyAcceptWb = 1'b0;
    w_lowestWb    = 1'b0;
    w_lowest      = '0;
    for (int i = NumAcc - 1; i >= 0; i--) begin
      if (prd_rsp_i[i].p_accept) begin
        w_anyAccept = 1'b1;
        w_lowest    = TgtW'(i);
        w_lowestWb  = |prd_rsp_i[i].p_writeback;
        if (|prd_rsp_i[i].p_writeback) begin
          w_anyAcceptWb = 1'b1;
        end
      end
    end
  end

  assign w_atLimit    = (r_count == CntW'(MaxOutstanding));
  assign w_qReady     = rst_ni && (r_state == DISP_IDLE) && !(w_anyAcceptWb && w_atLimit);
  assign w_acceptFire = core_q_valid_i && w_qReady && w_anyAccept;

  always_comb begin
    w_nextState     = r_state;
    core_q_ready_o  = 1'b0;
    core_k_accept_o = 1'b0;
    core_k_wb_o     = 1'b0;
    acc_q_valid_o   = '0;
    unique case (r_state)
      DISP_IDLE: begin
        core_q_ready_o  = w_qReady;
        core_k_accept_o = w_anyAccept;
        core_k_wb_o     = w_anyAccept && w_lowestWb;
        if (w_acceptFire) begin
          w_nextState = DISP_ISSUE;
        end
      end
      DISP_ISSUE: begin
        acc_q_valid_o[r_target] = 1'b1;
        if (acc_q_ready_i[r_target]) begin
          w_nextState = DISP_IDLE;
        end
      end
      default: w_nextState = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= DISP_IDLE;
      r_target <= '0;
      r_req    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_acceptFire) begin
        r_target    <= w_lowest;
        r_req.instr <= core_q_instr_i;
        r_req.rs    <= core_q_rs_i;
        r_req.rd    <= core_q_rd_i;
      end
    end
  end

  assign acc_q_o = r_req;

  assign w_inc = w_acceptFire && w_lowestWb;
  assign w_dec = r_rspValid && core_p_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      unique case ({w_inc, w_dec})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The output register refills whenever it is empty or being drained this cycle.
  assign w_load = !r_rspValid || core_p_ready_i;

  acc_rr_arb #(
    .NumAcc (NumAcc)
  ) u_rspArb (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_req     (acc_p_valid_i),
    .i_advance (w_load),
    .o_grant   (w_grant),
    .o_valid   (w_grantValid)
  );

  assign acc_p_ready_o = (rst_ni && w_load) ? w_grant : '0;

  always_comb begin
    w_rspSel = '0;
    for (int i = 0; i < NumAcc; i++) begin
      if (w_grant[i]) begin
        w_rspSel = acc_p_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rspValid <= 1'b0;
      r_rsp      <= '0;
    end else if (w_load) begin
      r_rspValid <= w_grantValid;
      if (w_grantValid) begin
        r_rsp <= w_rspSel;
      end
    end
  end

  assign core_p_valid_o = r_rspValid;
  assign core_p_o       = r_rsp;

  a_noUnderflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_dec |-> (r_count != '0));

endmodule

// File: tb/tb_acc_offload_dispatcher.sv
// Self-checking bench: directed literal scenarios, then randomized traffic
// compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_acc_offload_dispatcher;
  import acc_pkg::*;

  localparam int NumAcc = 4;
  localparam int MaxOut = 4;
  localparam int DW     = 32;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  core_q_valid_i;
  logic                  core_q_ready_o;
  logic [31:0]           core_q_instr_i;
  logic [3*DW-1:0]       core_q_rs_i;
  logic [4:0]            core_q_rd_i;
  logic                  core_k_accept_o;
  logic                  core_k_wb_o;
  prd_req_t              prd_req_o;
  prd_rsp_t [NumAcc-1:0] prd_rsp_i;
  logic [NumAcc-1:0]     acc_q_valid_o;
  logic [NumAcc-1:0]     acc_q_ready_i;
  acc_req_t              acc_q_o;
  logic [NumAcc-1:0]     acc_p_valid_i;
  logic [NumAcc-1:0]     acc_p_ready_o;
  acc_rsp_t [NumAcc-1:0] acc_p_i;
  logic                  core_p_valid_o;
  logic                  core_p_ready_i;
  acc_rsp_t              core_p_o;

  int vectors = 0;
  int miscompares = 0;

  acc_offload_dispatcher #(
    .NumAcc(NumAcc), .MaxOutstanding(MaxOut), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
    .core_q_instr_i(core_q_instr_i), .core_q_rs_i(core_q_rs_i), .core_q_rd_i(core_q_rd_i),
    .core_k_accept_o(core_k_accept_o), .core_k_wb_o(core_k_wb_o),
    .prd_req_o(prd_req_o), .prd_rsp_i(prd_rsp_i),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i), .acc_q_o(acc_q_o),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o), .acc_p_i(acc_p_i),
    .core_p_valid_o(core_p_valid_o), .core_p_ready_i(core_p_ready_i), .core_p_o(core_p_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearInputs();
    core_q_valid_i = 1'b0;
    core_q_instr_i = '0;
    core_q_rs_i    = '0;
    core_q_rd_i    = '0;
    prd_rsp_i      = '0;
    acc_q_ready_i  = '0;
    acc_p_valid_i  = '0;
    acc_p_i        = '0;
    core_p_ready_i = 1'b0;
  endtask

  // Issue one instruction to acc0 and complete its request handshake.
  task automatic issueOne(input logic wb, input string tag);
    prd_rsp_i = '0;
    prd_rsp_i[0].p_accept    = 1'b1;
    prd_rsp_i[0].p_writeback = wb ? 2'b01 : 2'b00;
    core_q_valid_i = 1'b1;
    core_q_instr_i = $urandom;
    #1 checkOutput({tag, "_qready"}, core_q_ready_o, 1'b1);
    tick();
    core_q_valid_i = 1'b0;
    prd_rsp_i      = '0;
    acc_q_ready_i  = 4'b0001;
    #1 checkOutput({tag, "_accqvalid"}, acc_q_valid_o, 4'b0001);
    tick();
    acc_q_ready_i = '0;
  endtask

  // Behavioural model state
  bit       mBusy;
  int       mTarget;
  acc_req_t mReq;
  bit       mReqWb;
  int       mCount;
  int       mPtr;
  bit       mRspValid;
  acc_rsp_t mRsp;
  acc_rsp_t pendQ[NumAcc][$];

  task automatic applyStimulus();
    core_q_valid_i = ($urandom_range(0, 2) != 0);
    core_q_instr_i = $urandom;
    core_q_rs_i    = {$urandom, $urandom, $urandom};
    core_q_rd_i    = 5'($urandom_range(0, 31));
    for (int a = 0; a < NumAcc; a++) begin
      prd_rsp_i[a].p_accept    = ($urandom_range(0, 2) == 0);
      prd_rsp_i[a].p_writeback = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      acc_p_valid_i[a] = (pendQ[a].size() > 0) && ($urandom_range(0, 3) != 0);
      acc_p_i[a] = acc_p_valid_i[a] ? pendQ[a][0] : acc_rsp_t'({$urandom, 5'($urandom)});
    end
    acc_q_ready_i  = 4'($urandom);
    core_p_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic modelCycle();
    bit anyAcc, anyAccWb, expReady, qFire, load;
    int low, win, idx;
    logic [3:0] expVec;
    anyAcc = 0; anyAccWb = 0; low = -1; win = -1;
    for (int a = 0; a < NumAcc; a++) begin
      if (prd_rsp_i[a].p_accept) begin
        anyAcc = 1;
        if (low < 0) low = a;
        if (prd_rsp_i[a].p_writeback != 0) anyAccWb = 1;
      end
    end
    expReady = !mBusy && !(anyAccWb && mCount == MaxOut);
    checkOutput("q_ready", core_q_ready_o, expReady);
    qFire = core_q_valid_i && expReady;
    if (qFire) begin
      checkOutput("k_accept", core_k_accept_o, anyAcc);
      if (anyAcc) checkOutput("k_wb", core_k_wb_o, prd_rsp_i[low].p_writeback != 0);
    end
    checkOutput("prd_req", prd_req_o.instr, core_q_instr_i);
    expVec = mBusy ? 4'(1 << mTarget) : 4'b0000;
    checkOutput("acc_q_valid", acc_q_valid_o, expVec);
    if (mBusy) checkOutput("acc_q_payload", acc_q_o, mReq);
    checkOutput("core_p_valid", core_p_valid_o, mRspValid);
    if (mRspValid) checkOutput("core_p_payload", core_p_o, mRsp);
    load = !mRspValid || core_p_ready_i;
    if (load) begin
      for (int k = 0; k < NumAcc; k++) begin
        idx = (mPtr + k) % NumAcc;
        if (win < 0 && acc_p_valid_i[idx]) win = idx;
      end
    end
    expVec = (win >= 0) ? 4'(1 << win) : 4'b0000;
    checkOutput("acc_p_ready", acc_p_ready_o, expVec);

    if (mRspValid && core_p_ready_i) mCount--;
    if (mBusy) begin
      if (acc_q_ready_i[mTarget]) begin
        mBusy = 0;
        if (mReqWb) pendQ[mTarget].push_back(acc_rsp_t'({$urandom, mReq.rd}));
      end
    end else if (qFire && anyAcc) begin
      mBusy     = 1;
      mTarget   = low;
      mReq.instr = core_q_instr_i;
      mReq.rs    = core_q_rs_i;
      mReq.rd    = core_q_rd_i;
      mReqWb    = (prd_rsp_i[low].p_writeback != 0);
      if (mReqWb) mCount++;
    end
    if (load) begin
      if (win >= 0) begin
        mRsp      = pendQ[win].pop_front();
        mRspValid = 1;
        mPtr      = (win + 1) % NumAcc;
      end else begin
        mRspValid = 0;
      end
    end
  endtask

  logic [3:0]  expGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] expData  [5] = '{32'h0, 32'hDEADBEEF, 32'h101, 32'h102, 32'h103};
  logic        expQRdy  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    clearInputs();
    acc_p_valid_i = 4'b1111;
    #3;
    checkOutput("rst_q_ready", core_q_ready_o, 1'b0);
    checkOutput("rst_acc_q_valid", acc_q_valid_o, 4'b0000);
    checkOutput("rst_acc_p_ready", acc_p_ready_o, 4'b0000);
    checkOutput("rst_core_p_valid", core_p_valid_o, 1'b0);
    acc_p_valid_i = '0;
    #9 rst_ni = 1'b1;
    tick();
    checkOutput("idle_q_ready", core_q_ready_o, 1'b1);

    // acc1 and acc2 accept a non-writeback instruction; acc1 must win
    prd_rsp_i[1].p_accept = 1'b1;
    prd_rsp_i[2].p_accept = 1'b1;
    core_q_valid_i = 1'b1;
    core_q_instr_i = 32'h0000_1234;
    core_q_rd_i    = 5'd7;
    #1 checkOutput("t1_q_ready", core_q_ready_o, 1'b1);
    checkOutput("t1_k_accept", core_k_accept_o, 1'b1);
    checkOutput("t1_k_wb", core_k_wb_o, 1'b0);
    tick();
    clearInputs();
    acc_q_ready_i = 4'b1101;
    #1 checkOutput("t1_acc_q_valid", acc_q_valid_o, 4'b0010);
    checkOutput("t1_acc_q_instr", acc_q_o.instr, 32'h0000_1234);
    checkOutput("t1_acc_q_rd", acc_q_o.rd, 5'd7);
    checkOutput("t1_issue_q_ready", core_q_ready_o, 1'b0);
    tick();
    checkOutput("t1_hold_valid", acc_q_valid_o, 4'b0010);
    acc_q_ready_i = 4'b0010;
    tick();
    acc_q_ready_i = '0;
    checkOutput("t1_done_valid", acc_q_valid_o, 4'b0000);
    checkOutput("t1_done_ready", core_q_ready_o, 1'b1);

    // Illegal instruction: nobody accepts
    core_q_valid_i = 1'b1;
    core_q_instr_i = 32'hFFFF_FFFF;
    #1 checkOutput("t2_q_ready", core_q_ready_o, 1'b1);
    checkOutput("t2_k_accept", core_k_accept_o, 1'b0);
    tick();
    core_q_valid_i = 1'b0;
    checkOutput("t2_acc_q_valid", acc_q_valid_o, 4'b0000);
    checkOutput("t2_still_idle", core_q_ready_o, 1'b1);

    // Fill the outstanding window, then a writeback instr must stall
    for (int i = 0; i < MaxOut; i++) issueOne(1'b1, "t3_fill");
    prd_rsp_i[0].p_accept    = 1'b1;
    prd_rsp_i[0].p_writeback = 2'b01;
    prd_rsp_i[2].p_accept    = 1'b1;
    core_q_valid_i = 1'b1;
    #1 checkOutput("t3_block", core_q_ready_o, 1'b0);
    tick();
    checkOutput("t3_block2", core_q_ready_o, 1'b0);
    checkOutput("t3_no_issue", acc_q_valid_o, 4'b0000);
    prd_rsp_i = '0;
    prd_rsp_i[0].p_accept = 1'b1;
    #1 checkOutput("t3_nowb_ready", core_q_ready_o, 1'b1);
    checkOutput("t3_nowb_k_wb", core_k_wb_o, 1'b0);
    tick();
    core_q_valid_i = 1'b0;
    prd_rsp_i      = '0;
    acc_q_ready_i  = 4'b0001;
    #1 checkOutput("t3_nowb_issue", acc_q_valid_o, 4'b0001);
    tick();
    acc_q_ready_i = '0;

    // All accelerators respond at once: grants rotate 0,1,2,3,0
    prd_rsp_i[0].p_accept    = 1'b1;
    prd_rsp_i[0].p_writeback = 2'b01;
    acc_p_valid_i  = 4'b1111;
    for (int a = 0; a < NumAcc; a++) begin
      acc_p_i[a].data = (a == 0) ? 32'hDEADBEEF : 32'(32'h100 + a);
      acc_p_i[a].rd   = 5'(a);
    end
    core_p_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 checkOutput("t4_grant", acc_p_ready_o, expGrant[c]);
      checkOutput("t4_p_valid", core_p_valid_o, c != 0);
      if (c != 0) checkOutput("t4_p_data", core_p_o.data, expData[c]);
      checkOutput("t4_q_ready", core_q_ready_o, expQRdy[c]);
      tick();
    end

    // Stall the core response port for three cycles
    core_p_ready_i = 1'b0;
    core_q_valid_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1 checkOutput("t5_p_valid", core_p_valid_o, 1'b1);
      checkOutput("t5_p_data", core_p_o.data, 32'hDEADBEEF);
      checkOutput("t5_p_rd", core_p_o.rd, 5'd0);
      checkOutput("t5_no_p_ready", acc_p_ready_o, 4'b0000);
      if (s == 0) checkOutput("t5_wb_accept", core_q_ready_o & core_k_wb_o, 1'b1);
      tick();
      core_q_valid_i = 1'b0;
      prd_rsp_i      = '0;
    end

    // Asynchronous reset while in ISSUE with a response pending
    checkOutput("t6_pre_issue", acc_q_valid_o, 4'b0001);
    rst_ni = 1'b0;
    #1 checkOutput("t6_acc_q_valid", acc_q_valid_o, 4'b0000);
    checkOutput("t6_core_p_valid", core_p_valid_o, 1'b0);
    checkOutput("t6_acc_p_ready", acc_p_ready_o, 4'b0000);
    checkOutput("t6_q_ready", core_q_ready_o, 1'b0);
    @(negedge clk_i);
    clearInputs();
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < MaxOut; i++) issueOne(1'b1, "t6_refill");
    prd_rsp_i[0].p_accept    = 1'b1;
    prd_rsp_i[0].p_writeback = 2'b10;
    #1 checkOutput("t6_full_again", core_q_ready_o, 1'b0);

    // Randomized traffic against the behavioural model
    clearInputs();
    rst_ni = 1'b0;
    #3 rst_ni = 1'b1;
    mBusy = 0; mTarget = 0; mReq = '0; mReqWb = 0; mCount = 0; mPtr = 0;
    mRspValid = 0; mRsp = '0;
    for (int a = 0; a < NumAcc; a++) pendQ[a].delete();
    for (int n = 0; n < 3000; n++) begin
      tick();
      applyStimulus();
      #1 modelCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
